// File: rtl/i2c_reg_seq_pkg.sv
// Shared constants and state encoding for the I2C register-transaction sequencer.
package i2c_reg_seq_pkg;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_FIFO     = 3'd1;
    localparam logic [2:0] REG_CMD_ADDR = 3'd2;
    localparam logic [2:0] REG_CMD      = 3'd3;
    localparam logic [2:0] REG_DATA     = 3'd4;
    localparam logic [2:0] REG_PRE_L    = 3'd6;
    localparam logic [2:0] REG_PRE_H    = 3'd7;

    localparam int CMD_START = 0;
    localparam int CMD_READ  = 1;
    localparam int CMD_WRITE = 2;
    localparam int CMD_STOP  = 4;

    localparam logic [7:0] CMD_START_WR = 8'h05;
    localparam logic [7:0] CMD_WR_STOP  = 8'h14;
    localparam logic [7:0] CMD_RD_STOP  = 8'h13;

    localparam int ST_BUSY       = 0;
    localparam int ST_MISSED_ACK = 3;
    localparam int FS_CMD_EMPTY  = 0;
    localparam int FS_WR_EMPTY   = 3;

    localparam logic [7:0] ST_CLR_NACK = 8'h08;

    typedef enum logic [3:0] {
        S_INIT_PL,
        S_INIT_PH,
        S_IDLE,
        S_ISSUE,
        S_POLL_FIFO,
        S_POLL_STAT,
        S_CLR_NACK,
        S_READ_DATA,
        S_RESP
    } state_e;

endpackage

// File: rtl/i2c_reg_seq_wb_master_8.sv
// Single-access 8-bit Wishbone master: a start request launches one
// registered access which is held until acked.
module wb_master_8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       we,
    input  logic [2:0] adr,
    input  logic [7:0] wdat,
    output logic       done,
    output logic [7:0] rdat,
    output logic [2:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    output logic       wbm_we_o,
    output logic       wbm_stb_o,
    output logic       wbm_cyc_o,
    input  logic       wbm_ack_i
);

    logic       stb_q, stb_d;
    logic       we_q, we_d;
    logic [2:0] adr_q, adr_d;
    logic [7:0] dat_q, dat_d;

    // Start is ignored while an access is open, so the cycle after an ack
    // is always idle on the bus.
    always_comb begin
        stb_d = stb_q;
        we_d  = we_q;
        adr_d = adr_q;
        dat_d = dat_q;
        if (stb_q) begin
            if (wbm_ack_i) begin
                stb_d = 1'b0;
                we_d  = 1'b0;
                adr_d = 3'd0;
                dat_d = 8'h00;
            end
        end else if (start) begin
            stb_d = 1'b1;
            we_d  = we;
            adr_d = adr;
            dat_d = we ? wdat : 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= 3'd0;
            dat_q <= 8'h00;
        end else begin
            stb_q <= stb_d;
            we_q  <= we_d;
            adr_q <= adr_d;
            dat_q <= dat_d;
        end
    end

    assign done      = stb_q & wbm_ack_i;
    assign rdat      = wbm_dat_i;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_we_o  = we_q;
    assign wbm_stb_o = stb_q;
    assign wbm_cyc_o = stb_q;

endmodule

// File: rtl/i2c_reg_seq.sv
// Converts single device-register read/write requests into the register
// access script of an i2c_master_wbs_8 and reports data, NACK and timeout.
module i2c_reg_seq
    import i2c_reg_seq_pkg::*;
#(
    parameter logic [15:0] PRESCALE   = 16'd1,
    parameter int          POLL_LIMIT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_read,
    input  logic [6:0] req_dev_addr,
    input  logic [7:0] req_reg_addr,
    input  logic [7:0] req_wr_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic       rsp_timeout,
    output logic [2:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    output logic       wbm_we_o,
    output logic       wbm_stb_o,
    output logic       wbm_cyc_o,
    input  logic       wbm_ack_i
);

    localparam int CW = $clog2(POLL_LIMIT + 1);

    state_e        state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [6:0]    dev_q, dev_d;
    logic [7:0]    reg_q, reg_d, wd_q, wd_d, data_q, data_d;
    logic          rd_q, rd_d, nack_q, nack_d, to_q, to_d;

    logic          acc_want, acc_we, acc_done;
    logic [2:0]    acc_adr, scr_adr;
    logic [7:0]    acc_wdat, scr_dat, acc_rdat;
    logic          script_end, limit_hit;

    always_comb begin
        scr_adr = REG_CMD;
        scr_dat = CMD_WR_STOP;
        case (step_q)
            3'd0: begin scr_adr = REG_CMD_ADDR; scr_dat = {1'b0, dev_q}; end
            3'd1: begin scr_adr = REG_DATA;     scr_dat = reg_q;         end
            3'd2: begin scr_adr = REG_CMD;      scr_dat = CMD_START_WR;  end
            3'd3: begin
                scr_adr = rd_q ? REG_CMD : REG_DATA;
                scr_dat = rd_q ? CMD_RD_STOP : wd_q;
            end
            default: ;
        endcase
    end

    assign script_end = (step_q == (rd_q ? 3'd3 : 3'd4));
    // Saturate so a fifo success on the last allowed read still gets one
    // STATUS read before timing out.
    assign cnt_inc    = (cnt_q == CW'(POLL_LIMIT)) ? cnt_q : cnt_q + 1'b1;
    assign limit_hit  = (cnt_q >= CW'(POLL_LIMIT - 1));

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        dev_d    = dev_q;
        reg_d    = reg_q;
        wd_d     = wd_q;
        rd_d     = rd_q;
        nack_d   = nack_q;
        to_d     = to_q;
        data_d   = data_q;
        acc_want = 1'b0;
        acc_we   = 1'b0;
        acc_adr  = 3'd0;
        acc_wdat = 8'h00;
        case (state_q)
            S_INIT_PL: begin
                acc_want = 1'b1;
                acc_we   = 1'b1;
                acc_adr  = REG_PRE_L;
                acc_wdat = PRESCALE[7:0];
                if (acc_done) state_d = S_INIT_PH;
            end
            S_INIT_PH: begin
                acc_want = 1'b1;
                acc_we   = 1'b1;
                acc_adr  = REG_PRE_H;
                acc_wdat = PRESCALE[15:8];
                if (acc_done) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (req_valid) begin
                    dev_d   = req_dev_addr;
                    reg_d   = req_reg_addr;
                    wd_d    = req_wr_data;
                    rd_d    = req_read;
                    nack_d  = 1'b0;
                    to_d    = 1'b0;
                    data_d  = 8'h00;
                    step_d  = 3'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                acc_want = 1'b1;
                acc_we   = 1'b1;
                acc_adr  = scr_adr;
                acc_wdat = scr_dat;
                if (acc_done) begin
                    step_d = step_q + 3'd1;
                    if (script_end) begin
                        cnt_d   = '0;
                        state_d = S_POLL_FIFO;
                    end
                end
            end
            S_POLL_FIFO: begin
                acc_want = 1'b1;
                acc_adr  = REG_FIFO;
                if (acc_done) begin
                    cnt_d = cnt_inc;
                    if (acc_rdat[FS_CMD_EMPTY] && acc_rdat[FS_WR_EMPTY]) begin
                        state_d = S_POLL_STAT;
                    end else if (limit_hit) begin
                        to_d    = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_POLL_STAT: begin
                acc_want = 1'b1;
                acc_adr  = REG_STATUS;
                if (acc_done) begin
                    cnt_d  = cnt_inc;
                    nack_d = nack_q | acc_rdat[ST_MISSED_ACK];
                    if (!acc_rdat[ST_BUSY]) begin
                        if (nack_d)    state_d = S_CLR_NACK;
                        else if (rd_q) state_d = S_READ_DATA;
                        else           state_d = S_RESP;
                    end else if (limit_hit) begin
                        to_d    = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_CLR_NACK: begin
                acc_want = 1'b1;
                acc_we   = 1'b1;
                acc_adr  = REG_STATUS;
                acc_wdat = ST_CLR_NACK;
                if (acc_done) state_d = S_RESP;
            end
            S_READ_DATA: begin
                acc_want = 1'b1;
                acc_adr  = REG_DATA;
                if (acc_done) begin
                    data_d  = acc_rdat;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_INIT_PL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT_PL;
            step_q  <= 3'd0;
            cnt_q   <= '0;
            dev_q   <= 7'd0;
            reg_q   <= 8'h00;
            wd_q    <= 8'h00;
            rd_q    <= 1'b0;
            nack_q  <= 1'b0;
            to_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            nack_q  <= nack_d;
            to_q    <= to_d;
            data_q  <= data_d;
        end
    end

    wb_master_8 u_wbm (
        .clk       (clk),
        .rst       (rst),
        .start     (acc_want),
        .we        (acc_we),
        .adr       (acc_adr),
        .wdat      (acc_wdat),
        .done      (acc_done),
        .rdat      (acc_rdat),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_we_o  (wbm_we_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_ack_i (wbm_ack_i)
    );

    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_data    = data_q;
    assign rsp_nack    = nack_q;
    assign rsp_timeout = to_q;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Self-checking bench for i2c_reg_seq with a behavioural I2C-master slave
// model and a transaction-level reference for the expected access list.
module tb_i2c_reg_seq;

    localparam int LIM = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_read = 1'b0;
    logic [6:0] req_dev_addr = 7'd0;
    logic [7:0] req_reg_addr = 8'h00;
    logic [7:0] req_wr_data = 8'h00;
    logic [7:0] wbm_dat_i = 8'h00;
    logic       wbm_ack_i = 1'b0;
    logic       req_ready, rsp_valid, rsp_nack, rsp_timeout;
    logic [7:0] rsp_data, wbm_dat_o;
    logic [2:0] wbm_adr_o;
    logic       wbm_we_o, wbm_stb_o, wbm_cyc_o;

    always #5 clk = ~clk;

    i2c_reg_seq #(.PRESCALE(16'h0001), .POLL_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
        .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr),
        .req_wr_data(req_wr_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
        .rsp_timeout(rsp_timeout),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
        .wbm_ack_i(wbm_ack_i)
    );

    typedef struct packed {
        logic       we;
        logic [2:0] adr;
        logic [7:0] dat;
    } acc_t;

    int   vectors = 0;
    int   errors = 0;
    int   ack_mode = 1;
    bit   spur_en = 0;
    int   fifo_left = 0;
    int   busy_left = 0;
    bit   nack_bit = 0;
    logic [7:0] data_byte = 8'h00;
    int   rsp_cnt = 0;
    acc_t obs_q[$];
    acc_t exp_q[$];
    logic       exp_nack, exp_to;
    logic [7:0] exp_data;

    function automatic acc_t mk(input logic we, input logic [2:0] adr,
                                input logic [7:0] dat);
        acc_t a;
        a.we = we;
        a.adr = adr;
        a.dat = dat;
        return a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave model of the I2C master register file.
    task automatic serve();
        acc_t a;
        logic [7:0] r;
        a.we  = wbm_we_o;
        a.adr = wbm_adr_o;
        a.dat = wbm_we_o ? wbm_dat_o : 8'h00;
        obs_q.push_back(a);
        r = 8'($urandom);
        if (wbm_we_o) begin
            if (wbm_adr_o == 3'd0 && wbm_dat_o[3]) nack_bit = 0;
        end else begin
            case (wbm_adr_o)
                3'd1: begin
                    if (fifo_left > 0) begin
                        fifo_left--;
                        r[$urandom_range(0, 1) * 3] = 1'b0;
                    end else begin
                        r = r | 8'h09;
                    end
                end
                3'd0: begin
                    r[3] = nack_bit;
                    r[0] = (busy_left > 0);
                    if (busy_left > 0) busy_left--;
                end
                3'd4: r = data_byte;
                default: ;
            endcase
        end
        wbm_dat_i = r;
    endtask

    always @(posedge clk) begin
        #1;
        if (rst) begin
            wbm_ack_i = 1'b0;
        end else if (wbm_ack_i) begin
            wbm_ack_i = 1'b0;
        end else if (wbm_cyc_o && wbm_stb_o) begin
            if (ack_mode == 1 || $urandom_range(0, 2) != 0) begin
                wbm_ack_i = 1'b1;
                serve();
            end
        end else if (spur_en && $urandom_range(0, 5) == 0) begin
            wbm_ack_i = 1'b1;
            wbm_dat_i = 8'hFF;
        end
    end

    always @(posedge clk) if (rsp_valid) rsp_cnt++;

    // Reference: script, then poll reads sharing one budget of LIM reads.
    task automatic model(input bit rd, input logic [6:0] dev,
                         input logic [7:0] ra, input logic [7:0] wd,
                         input int ff, input int bp, input bit ns,
                         input logic [7:0] rdb);
        int fifo_reads, remaining, stat_reads;
        exp_q.delete();
        exp_q.push_back(mk(1, 2, {1'b0, dev}));
        exp_q.push_back(mk(1, 4, ra));
        exp_q.push_back(mk(1, 3, 8'h05));
        if (rd) begin
            exp_q.push_back(mk(1, 3, 8'h13));
        end else begin
            exp_q.push_back(mk(1, 4, wd));
            exp_q.push_back(mk(1, 3, 8'h14));
        end
        exp_nack = 0;
        exp_data = 8'h00;
        fifo_reads = (ff + 1 < LIM) ? ff + 1 : LIM;
        for (int i = 0; i < fifo_reads; i++) exp_q.push_back(mk(0, 1, 0));
        if (ff >= LIM) begin
            exp_to = 1;
            return;
        end
        remaining = (LIM - fifo_reads > 1) ? LIM - fifo_reads : 1;
        stat_reads = (bp < remaining) ? bp + 1 : remaining;
        for (int i = 0; i < stat_reads; i++) exp_q.push_back(mk(0, 0, 0));
        exp_to = (bp >= remaining);
        exp_nack = ns;
        if (!exp_to && ns) exp_q.push_back(mk(1, 0, 8'h08));
        if (!exp_to && !ns && rd) begin
            exp_q.push_back(mk(0, 4, 0));
            exp_data = rdb;
        end
    endtask

    task automatic compare_accs(input string tag);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check(tag, 32'(obs_q[i]), 32'(exp_q[i]));
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, req_ready, 1);
    endtask

    task automatic init_expect();
        exp_q.delete();
        exp_q.push_back(mk(1, 6, 8'h01));
        exp_q.push_back(mk(1, 7, 8'h00));
    endtask

    task automatic run_txn(input string tag, input bit rd,
                           input logic [6:0] dev, input logic [7:0] ra,
                           input logic [7:0] wd, input int ff, input int bp,
                           input bit ns, input logic [7:0] rdb);
        int n;
        int c0;
        wait_ready({tag, "_ready"});
        fifo_left = ff;
        busy_left = bp;
        nack_bit = ns;
        data_byte = rdb;
        obs_q.delete();
        model(rd, dev, ra, wd, ff, bp, ns, rdb);
        c0 = rsp_cnt;
        req_valid = 1'b1;
        req_read = rd;
        req_dev_addr = dev;
        req_reg_addr = ra;
        req_wr_data = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_dev_addr = 7'($urandom);
        req_reg_addr = 8'($urandom);
        req_wr_data = 8'($urandom);
        check({tag, "_ready_drop"}, req_ready, 0);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_rsp_data"}, rsp_data, exp_data);
        check({tag, "_rsp_nack"}, rsp_nack, exp_nack);
        check({tag, "_rsp_timeout"}, rsp_timeout, exp_to);
        compare_accs({tag, "_acc"});
        @(negedge clk);
        check({tag, "_pulse"}, rsp_valid, 0);
        check({tag, "_rsp_once"}, rsp_cnt - c0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cyc"}, wbm_cyc_o, 0);
        check({tag, "_stb"}, wbm_stb_o, 0);
        check({tag, "_we"}, wbm_we_o, 0);
        check({tag, "_adr"}, wbm_adr_o, 0);
        check({tag, "_dat"}, wbm_dat_o, 0);
        check({tag, "_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_nack"}, rsp_nack, 0);
        check({tag, "_rsp_timeout"}, rsp_timeout, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        obs_q.delete();
        rst = 1'b0;
        wait_ready("init_ready");
        init_expect();
        compare_accs("init");

        run_txn("wr", 0, 7'h50, 8'h10, 8'hA5, 0, 0, 0, 8'h00);
        run_txn("rd", 1, 7'h68, 8'h75, 8'h00, 0, 0, 0, 8'h71);
        run_txn("nack_rd", 1, 7'h22, 8'h01, 8'h00, 0, 0, 1, 8'h5A);
        run_txn("nack_wr", 0, 7'h23, 8'h02, 8'h3C, 1, 2, 1, 8'h00);
        run_txn("busy_to", 0, 7'h31, 8'h40, 8'h77, 0, 50, 0, 8'h00);
        run_txn("fifo_to", 1, 7'h32, 8'h41, 8'h00, 20, 0, 0, 8'h99);
        run_txn("to_nack", 1, 7'h33, 8'h42, 8'h00, 2, 50, 1, 8'h99);
        run_txn("edge_last", 1, 7'h34, 8'h43, 8'h00, LIM - 1, 0, 0, 8'hC3);

        // Asynchronous reset while CMD <- 0x05 is on the bus.
        ack_mode = 0;
        wait_ready("mid_ready");
        fifo_left = 0;
        busy_left = 0;
        nack_bit = 0;
        req_valid = 1'b1;
        req_read = 1'b0;
        req_dev_addr = 7'h50;
        req_reg_addr = 8'h10;
        req_wr_data = 8'hA5;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(wbm_stb_o && wbm_adr_o == 3'd3 && wbm_dat_o == 8'h05)
               && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_step3_seen", n < 100, 1);
        c0 = rsp_cnt;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        obs_q.delete();
        rst = 1'b0;
        wait_ready("reinit_ready");
        init_expect();
        compare_accs("reinit");
        check("mid_no_rsp", rsp_cnt - c0, 0);

        spur_en = 1;
        for (int t = 0; t < 30; t++) begin
            bit rd, ns;
            int ff, bp;
            rd = 1'($urandom_range(0, 1));
            ns = ($urandom_range(0, 3) == 0);
            ff = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 10)
                                             : $urandom_range(0, 2);
            bp = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 10)
                                             : $urandom_range(0, 3);
            run_txn($sformatf("rnd%0d", t), rd, 7'($urandom),
                    8'($urandom), 8'($urandom), ff, bp, ns, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/i2c_reg_seq.md
# i2c_reg_seq

Register-transaction sequencer that drives the 8-bit Wishbone slave port of `i2c_master_wbs_8` as a Wishbone master. It accepts one device-register read or write request at a time over a valid/ready interface. It converts each request into a fixed series of register accesses on the I2C master and returns read data plus NACK and timeout status. It sits between firmware-free control logic, such as PMIC or clock-chip init and sensor polling, and the shared I2C master.

## Interface
- `PRESCALE`, default 1: 16-bit value programmed into the I2C master prescale registers after reset.
- `POLL_LIMIT`, default 1024: maximum number of completion-poll reads before a timeout is declared. Width is `$clog2(POLL_LIMIT+1)`.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer idle and initialised.
- `req_read`  in  1  1 = register read, 0 = register write.
- `req_dev_addr`  in  7  I2C 7-bit device address.
- `req_reg_addr`  in  8  device register index.
- `req_wr_data`  in  8  write byte; ignored on reads.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_data`  out  8  read byte; 0x00 on writes and on errors.
- `rsp_nack`  out  1  missed ACK was seen during the transaction.
- `rsp_timeout`  out  1  `POLL_LIMIT` was exhausted.
- `wbm_adr_o`  out  3  register address.
- `wbm_dat_o`  out  8  write data.
- `wbm_dat_i`  in  8  read data.
- `wbm_we_o`  out  1  write enable.
- `wbm_stb_o`  out  1  strobe.
- `wbm_cyc_o`  out  1  cycle.
- `wbm_ack_i`  in  1  acknowledge.

## Operation
- Register map used:
  - 0 STATUS: bit0 busy, bit3 missed_ack; writing bit3 = 1 clears missed_ack.
  - 1 FIFO_STATUS: bit0 cmd_empty, bit3 wr_empty.
  - 2 CMD_ADDR.
  - 3 CMD: bit0 start, bit1 read, bit2 write, bit4 stop.
  - 4 DATA.
  - 6 PRESCALE_L.
  - 7 PRESCALE_H.
- FSM states: INIT_PL → INIT_PH → IDLE → ISSUE → POLL_FIFO → POLL_STAT → CLR_NACK → (READ_DATA) → RESP → IDLE.
- INIT sequence after reset:
  1. Write PRESCALE_L = `PRESCALE[7:0]`.
  2. Write PRESCALE_H = `PRESCALE[15:8]`.
  3. Enter IDLE. `req_ready` is high only in IDLE.
- Request handling: a request is captured into internal registers on `req_valid && req_ready`.
- ISSUE write script:
  1. CMD_ADDR ← dev.
  2. DATA ← reg.
  3. CMD ← 0x05.
  4. DATA ← wdata.
  5. CMD ← 0x14.
- ISSUE read script:
  1. CMD_ADDR ← dev.
  2. DATA ← reg.
  3. CMD ← 0x05.
  4. CMD ← 0x13.
- A small step counter indexes the script; script entries are constant.
- POLL_FIFO: read FIFO_STATUS until bit0 and bit3 are both 1.
- POLL_STAT: read STATUS until bit0 = 0. Latch bit3 as the NACK flag.
- Poll counter behaviour:
  - A single counter is shared by both poll states and cleared on entry to POLL_FIFO.
  - On reaching `POLL_LIMIT` reads without success, go to RESP with `rsp_timeout` = 1. Skip CLR_NACK and READ_DATA.
- CLR_NACK: write STATUS ← 0x08, only if NACK was latched.
- READ_DATA (reads only, no NACK): read DATA and latch `rsp_data`.
- RESP: pulse `rsp_valid` for one cycle with the latched flags, then return to IDLE. No backpressure on responses.

## Timing
- Reset values: `wbm_cyc_o`, `wbm_stb_o` and `wbm_we_o` are 0; `wbm_adr_o` and `wbm_dat_o` are 0. `req_ready`, `rsp_valid`, `rsp_nack` and `rsp_timeout` are 0; `rsp_data` is 0x00. FSM is in INIT_PL.
- Wishbone access:
  - `cyc`/`stb`/`adr`/`dat`/`we` are registered and rise together.
  - They are held until the cycle `wbm_ack_i` is sampled high, then drop on the next edge.
  - There is at least one idle cycle between accesses.
  - `wbm_dat_i` is sampled in the ack cycle.
- `wbm_ack_i` outside an active strobe is ignored.
- The sequencer waits indefinitely for `wbm_ack_i`; there is no timeout on ack.
- `req_ready` falls on the edge after acceptance; a new request is not accepted until the cycle after `rsp_valid`.
- An async `rst` mid-transaction aborts immediately. It produces no `rsp_valid` and re-runs INIT.
- Timeout and NACK may both be reported only if the NACK flag was latched before POLL_STAT exhausted. Otherwise `rsp_nack` = 0.

## Structure
- Package `i2c_reg_seq_pkg` holds:
  - the register offsets (0–7);
  - the CMD bit positions and the 0x05/0x14/0x13 command constants;
  - the STATUS and FIFO_STATUS bit positions;
  - the FSM state enum.
- One sub-module, `wb_master_8`: a single-access Wishbone master with `start`, `we`, `adr`, `wdat` in and `done`, `rdat` out. The FSM sequences it.

## Test plan
- Reset release, with the slave acking each access in 1 cycle → writes (6, 0x01) then (7, 0x00); `req_ready` = 1 afterwards.
- Write request dev 0x50, reg 0x10, data 0xA5; slave reports FIFOs empty and busy = 0 → write sequence (2, 0x50), (4, 0x10), (3, 0x05), (4, 0xA5), (3, 0x14); then `rsp_valid` with `rsp_nack` = 0 and `rsp_data` 0x00.
- Read request dev 0x68, reg 0x75; DATA returns 0x71 → CMD writes 0x05 then 0x13; `rsp_data` = 0x71.
- STATUS returns 0x08 with busy = 0 → STATUS write of 0x08 follows; `rsp_nack` = 1; DATA is not read.
- Busy held at 1 with `POLL_LIMIT` = 8 → exactly 8 poll reads, then `rsp_timeout` = 1.
- `rst` asserted during ISSUE step 3 → outputs return to reset values the same cycle, and the INIT writes repeat.
